// File: rtl/outagu.sv
`default_nettype none
// ============================================================================
// Module   : outagu
// Purpose  : Output address generation unit. Accepts quantised bit-plane
//            words and writes each one to data memory. Addresses come from a
//            plane counter nested inside a two-level loop:
//            base + a + p, MSB plane first.
// Revision : 1.0 - initial release
// ============================================================================
module outagu #(
  parameter int BPREC    = 6,
  parameter int BDBANKA  = 15,
  parameter int BDBANKW  = 64,
  parameter int BWLENGTH = 8
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                start,
  input  logic [BPREC-1:0]    oprecision,
  input  logic [BDBANKA-1:0]  obaseaddr,
  input  logic [BDBANKA-1:0]  ojump0,
  input  logic [BDBANKA-1:0]  ojump1,
  input  logic [BDBANKA-1:0]  ojump2,
  input  logic [BWLENGTH-1:0] olength1,
  input  logic [BWLENGTH-1:0] olength2,
  input  logic                in_valid,
  input  logic [BDBANKW-1:0]  in_data,
  output logic                in_ready,
  output logic                out_we,
  output logic [BDBANKA-1:0]  out_addr,
  output logic [BDBANKW-1:0]  out_data,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Job configuration captured at start.
  logic [BPREC-1:0]    prec;
  logic [BDBANKA-1:0]  base;
  logic [BDBANKA-1:0]  jump0;
  logic [BDBANKA-1:0]  jump1;
  logic [BDBANKA-1:0]  jump2;
  logic [BWLENGTH-1:0] len1;
  logic [BWLENGTH-1:0] len2;

  // Loop state.
  logic [BPREC-1:0]    p;
  logic [BWLENGTH-1:0] c1;
  logic [BWLENGTH-1:0] c2;
  logic [BDBANKA-1:0]  a;

  logic                launch;
  logic                accept;
  logic                vec_end;
  logic                inner_end;
  logic                outer_end;
  logic                final_word;
  logic [BPREC-1:0]    prec_last;
  logic [BDBANKA-1:0]  wr_addr;

  // A zero precision still means one plane per vector.
  logic [BPREC-1:0]    prec_in;
  assign prec_in = (oprecision == '0) ? BPREC'(1) : oprecision;

  // Loop-boundary decode and the address of the word being accepted.
  assign launch     = start && (state == S_IDLE);
  assign accept     = in_valid && (state == S_RUN);
  assign prec_last  = prec - BPREC'(1);
  assign vec_end    = (p == prec_last);
  assign inner_end  = (c1 == len1);
  assign outer_end  = (c2 == len2);
  assign final_word = accept && vec_end && inner_end && outer_end;
  assign wr_addr    = base + a + BDBANKA'(p);

  // Handshake and status derive from the state alone, never from in_valid.
  assign in_ready = (state == S_RUN);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: DONE lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (final_word) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Configuration latch, loaded only when a job is launched from IDLE.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prec  <= BPREC'(1);
      base  <= '0;
      jump0 <= '0;
      jump1 <= '0;
      jump2 <= '0;
      len1  <= '0;
      len2  <= '0;
    end else if (launch) begin
      prec  <= prec_in;
      base  <= obaseaddr;
      jump0 <= ojump0;
      jump1 <= ojump1;
      jump2 <= ojump2;
      len1  <= olength1;
      len2  <= olength2;
    end
  end

  // Plane / loop counters and loop address; they advance only on acceptance.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      p  <= '0;
      c1 <= '0;
      c2 <= '0;
      a  <= '0;
    end else if (launch) begin
      p  <= '0;
      c1 <= '0;
      c2 <= '0;
      a  <= '0;
    end else if (accept) begin
      if (!vec_end) begin
        p <= p + BPREC'(1);
      end else begin
        p <= '0;
        if (!inner_end) begin
          c1 <= c1 + BWLENGTH'(1);
          a  <= a + jump0;
        end else begin
          c1 <= '0;
          if (!outer_end) begin
            c2 <= c2 + BWLENGTH'(1);
            a  <= a + jump1;
          end else begin
            // Final word of the job: outer jump closes the address walk.
            a  <= a + jump2;
          end
        end
      end
    end
  end

  // Registered write port: one strobe per accepted word, data held otherwise.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      out_we <= accept;
      if (accept) begin
        out_addr <= wr_addr;
        out_data <= in_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_outagu.sv
`default_nettype none
// ============================================================================
// Module   : tb_outagu
// Purpose  : Self-checking bench for outagu; directed jobs plus randomised
//            jobs compared against a loop-nest reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_outagu;

  localparam int BPREC    = 6;
  localparam int BDBANKA  = 15;
  localparam int BDBANKW  = 64;
  localparam int BWLENGTH = 8;
  localparam int AMASK    = (1 << BDBANKA) - 1;

  logic                clk = 1'b0;
  logic                clr_n = 1'b0;
  logic                start = 1'b0;
  logic [BPREC-1:0]    oprecision = '0;
  logic [BDBANKA-1:0]  obaseaddr = '0;
  logic [BDBANKA-1:0]  ojump0 = '0;
  logic [BDBANKA-1:0]  ojump1 = '0;
  logic [BDBANKA-1:0]  ojump2 = '0;
  logic [BWLENGTH-1:0] olength1 = '0;
  logic [BWLENGTH-1:0] olength2 = '0;
  logic                in_valid = 1'b0;
  logic [BDBANKW-1:0]  in_data = '0;
  logic                in_ready;
  logic                out_we;
  logic [BDBANKA-1:0]  out_addr;
  logic [BDBANKW-1:0]  out_data;
  logic                busy;
  logic                done;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  logic [BDBANKW-1:0] held_data = '0;

  outagu #(
    .BPREC(BPREC), .BDBANKA(BDBANKA), .BDBANKW(BDBANKW), .BWLENGTH(BWLENGTH)
  ) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .oprecision(oprecision),
    .obaseaddr(obaseaddr), .ojump0(ojump0), .ojump1(ojump1), .ojump2(ojump2),
    .olength1(olength1), .olength2(olength2), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_we(out_we),
    .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: enumerate the write addresses directly from the loop nest.
  task automatic build_model(input int prec, input int base, input int j0, input int j1,
                             input int j2, input int l1, input int l2);
    int a;
    int np;
    exp_q.delete();
    a  = 0;
    np = (prec == 0) ? 1 : prec;
    for (int v2 = 0; v2 <= l2; v2++) begin
      for (int v1 = 0; v1 <= l1; v1++) begin
        for (int pl = 0; pl < np; pl++) exp_q.push_back((base + a + pl) & AMASK);
        if (v1 < l1)      a = a + j0;
        else if (v2 < l2) a = a + j1;
        else              a = a + j2;
      end
    end
  endtask

  task automatic scramble_cfg;
    oprecision = BPREC'($urandom);
    obaseaddr  = BDBANKA'($urandom);
    ojump0     = BDBANKA'($urandom);
    ojump1     = BDBANKA'($urandom);
    ojump2     = BDBANKA'($urandom);
    olength1   = BWLENGTH'($urandom);
    olength2   = BWLENGTH'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_we"}, 64'(out_we), 64'd0);
    check_val({tag, "_done"}, 64'(done), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_ready"}, 64'(in_ready), 64'd0);
    check_val({tag, "_addr"}, 64'(out_addr), 64'd0);
    check_val({tag, "_data"}, out_data, 64'd0);
  endtask

  // vmode: 0 continuous valid, 1 alternating valid, 2 random valid.
  task automatic run_job(input int prec, input int base, input int j0, input int j1,
                         input int j2, input int l1, input int l2, input int vmode,
                         input int abort_after, input bit poke_start);
    int  total;
    int  n;
    int  cyc;
    bit  v;
    int  e_addr;
    logic [BDBANKW-1:0] e_data;
    build_model(prec, base, j0, j1, j2, l1, l2);
    total = exp_q.size();
    in_valid   = 1'b0;
    start      = 1'b1;
    oprecision = BPREC'(prec);
    obaseaddr  = BDBANKA'(base);
    ojump0     = BDBANKA'(j0);
    ojump1     = BDBANKA'(j1);
    ojump2     = BDBANKA'(j2);
    olength1   = BWLENGTH'(l1);
    olength2   = BWLENGTH'(l2);
    tick;
    start = 1'b0;
    scramble_cfg;
    check_val("start_busy", 64'(busy), 64'd1);
    check_val("start_we", 64'(out_we), 64'd0);
    n   = 0;
    cyc = 0;
    e_addr = 0;
    e_data = '0;
    forever begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      in_data  = {$urandom, $urandom};
      if (poke_start && cyc == 2) begin
        start = 1'b1;
        scramble_cfg;
      end
      check_val("run_ready", 64'(in_ready), 64'd1);
      if (v) begin
        e_addr = exp_q.pop_front();
        e_data = in_data;
        n++;
      end
      tick;
      start = 1'b0;
      cyc++;
      check_val("we", 64'(out_we), 64'(v));
      if (v) begin
        check_val("addr", 64'(out_addr), 64'(e_addr));
        check_val("data", out_data, e_data);
        held_data = e_data;
      end else begin
        check_val("data_held", out_data, held_data);
      end
      check_val("done", 64'(done), 64'(v && n == total));
      check_val("busy", 64'(busy), 64'd1);
      if (v && n == total) break;
      if (abort_after != 0 && n == abort_after) begin
        clr_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs("abort");
        held_data = '0;
        tick;
        tick;
        clr_n = 1'b1;
        tick;
        check_val("post_abort_we", 64'(out_we), 64'd0);
        check_val("post_abort_busy", 64'(busy), 64'd0);
        tick;
        check_val("post_abort_done", 64'(done), 64'd0);
        return;
      end
      if (cyc > 4000) begin
        check_val("job_timeout", 64'(cyc), 64'd0);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    tick;
    check_val("end_busy", 64'(busy), 64'd0);
    check_val("end_done", 64'(done), 64'd0);
    check_val("end_we", 64'(out_we), 64'd0);
    check_val("end_ready", 64'(in_ready), 64'd0);
    check_val("end_data_held", out_data, held_data);
  endtask

  // Main sequence: directed jobs first, then randomised jobs.
  initial begin
    #2;
    check_reset_outputs("reset");
    tick;
    clr_n = 1'b1;
    tick;
    tick;
    check_val("idle_busy", 64'(busy), 64'd0);

    run_job(2, 'h100, 2, 8, 0, 2, 0, 0, 0, 1'b0);
    run_job(1, 0, 1, 5, 0, 1, 1, 0, 0, 1'b0);
    run_job(2, 'h100, 2, 8, 0, 2, 0, 1, 0, 1'b0);
    run_job(2, 'h7FFF, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    run_job(2, 'h100, 2, 8, 0, 2, 0, 0, 3, 1'b0);
    run_job(2, 'h100, 2, 8, 0, 2, 0, 0, 0, 1'b0);
    run_job(0, 'h40, 3, 9, 1, 2, 1, 0, 0, 1'b1);

    for (int k = 0; k < 25; k++) begin
      run_job($urandom_range(0, 5), $urandom_range(0, AMASK), $urandom_range(0, AMASK),
              $urandom_range(0, AMASK), $urandom_range(0, AMASK), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 2), 0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/outagu.md
OUTAGU -- requirements
Module: outagu

Interface
REQ-001 Parameter BPREC, default 6, bitwidth of precision fields.
REQ-002 Parameter BDBANKA, default 15, data memory address width.
REQ-003 Parameter BDBANKW, default 64, data memory word width.
REQ-004 Parameter BWLENGTH, default 8, loop length width.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 clr_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle job launch pulse.
REQ-008 oprecision  in  BPREC  output bit-planes per vector.
REQ-009 obaseaddr  in  BDBANKA  job base write address.
REQ-010 ojump0 / ojump1 / ojump2  in  BDBANKA each  address increments: inner step / inner wrap / reserved-outer.
REQ-011 olength1 / olength2  in  BWLENGTH each  inner / outer loop iteration count minus 1.
REQ-012 in_valid  in  1  bit-plane word offered by the quantiser.
REQ-013 in_data  in  BDBANKW  bit-plane word.
REQ-014 in_ready  out  1  word accepted when in_valid && in_ready.
REQ-015 out_we  out  1  memory write strobe.
REQ-016 out_addr  out  BDBANKA  memory write address.
REQ-017 out_data  out  BDBANKW  memory write data.
REQ-018 busy  out  1  job in progress.
REQ-019 done  out  1  one-cycle job completion pulse.

Function
REQ-020 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on acceptance of the final word; DONE->IDLE unconditionally after one cycle.
REQ-021 On start in IDLE: latch oprecision, obaseaddr, ojump0-2, olength1-2; clear plane counter p, loop counters c1, c2, and loop address a to 0.
REQ-022 start outside IDLE is ignored; config inputs are don't-care outside the start cycle.
REQ-023 oprecision == 0 is latched as 1 (one plane per vector).
REQ-024 in_ready = 1 exactly when state == RUN; combinational from state only, never from in_valid.
REQ-025 Each accepted word is written at base + a + p, MSB plane first (p = 0 is MSB), sum truncated modulo 2^BDBANKA.
REQ-026 Write latency 1 cycle: out_we, out_addr, out_data registered from the accepting cycle; out_we high for exactly one cycle per accepted word.
REQ-027 On acceptance with p < prec-1: p increments; a, c1, c2 unchanged.
REQ-028 On acceptance with p == prec-1 (vector end): p <- 0; if c1 < olength1 then c1++, a += ojump0; else c1 <- 0, a += ojump1, and c2++ if c2 < olength2.
REQ-029 Final word = acceptance with p == prec-1, c1 == olength1, c2 == olength2; a += ojump2 is applied, then state -> DONE.
REQ-030 Total writes per job = prec * (olength1+1) * (olength2+1).
REQ-031 done = 1 for exactly the DONE cycle, coinciding with the final out_we pulse.
REQ-032 busy = 1 in RUN and DONE, 0 in IDLE.
REQ-033 in_valid low stalls all counters; no write issued.
REQ-034 out_data is held when out_we = 0.

Reset
REQ-035 clr_n low asynchronously forces IDLE, p = c1 = c2 = a = 0, out_we = 0, done = 0, busy = 0, in_ready = 0, out_addr = 0, out_data = 0.
REQ-036 Reset mid-job aborts without done; any write registered before reset assertion is lost if not yet issued; first job after release requires a new start.

Verification
REQ-037 prec=2, base=0x100, l1=2, l2=0, j0=2, j1=8, continuous valid -> writes 0x100,0x101,0x102,0x103,0x104,0x105; done with 6th out_we; busy 0 on the following cycle.
REQ-038 prec=1, base=0, l1=1, l2=1, j0=1, j1=5 -> addresses 0,1,6,7; 4 writes; done with 4th.
REQ-039 Same as REQ-037 with in_valid toggling 1,0,1,0 -> identical address sequence, out_we only one cycle after valid cycles, in_ready held 1.
REQ-040 base=0x7FFF, prec=2, l1=l2=0 -> addresses 0x7FFF then 0x0000 (wrap).
REQ-041 clr_n low after 3 writes of REQ-037 -> outputs 0 immediately, no done; start again -> sequence restarts at 0x100.
REQ-042 start pulsed during RUN and oprecision=0 at start -> start ignored, job unaffected; prec=0 job produces 1 write per vector.
